// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: operation encodings, issuer FSM states and FP32 values.
package fpu_pkg;

  typedef enum logic [1:0] {
    FPU_ADD = 2'b00,
    FPU_SUB = 2'b01,
    FPU_MUL = 2'b10,
    FPU_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issuer_state_e;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty; pointers carry one extra wrap bit.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             do_push, do_pop;

  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign wr_ptr_nxt = wr_ptr + PW'(do_push);
  assign rd_ptr_nxt = rd_ptr + PW'(do_pop);
  assign rd_data    = mem[rd_ptr[AW-1:0]];

  // Status is computed from next-state pointers so full/empty come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Queues tagged FPU commands, issues one at a time to the FPU and returns result+tag,
// aborting with rsp_err when the FPU does not answer within TIMEOUT issue cycles.
module fpu_cmd_issuer
  import fpu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             fpu_valid,
  output logic [1:0]       fpu_op_sel,
  output logic [31:0]      fpu_din1,
  output logic [31:0]      fpu_din2,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output issuer_state_e    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source holds
  // valid and its payload stable until that edge and never waits on ready to raise valid.

  localparam int FW    = 2 + 32 + 32 + TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [FW-1:0]    fifo_rd_data;
  logic             fifo_full, fifo_empty, pop, launch;
  logic [1:0]       q_op;
  logic [31:0]      q_a, q_b;
  logic [TAG_W-1:0] q_tag;

  issuer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fpu_valid_q, fpu_valid_d;
  fpu_op_e          op_q, op_d;
  logic [31:0]      din1_q, din1_d, din2_q, din2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  fpu_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {q_op, q_a, q_b, q_tag} = fifo_rd_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpu_valid_d  = fpu_valid_q;
    op_d         = op_q;
    din1_d       = din1_q;
    din2_d       = din2_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    launch       = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: launch = ~fifo_empty;
      ISSUE: begin
        // The first issue cycle ignores fpu_ready; a ready on the last cycle still wins.
        if (fpu_ready && (cnt_q != '0)) begin
          rsp_result_d = fpu_result;
          rsp_tag_d    = tag_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          fpu_valid_d  = 1'b0;
          state_d      = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rsp_result_d = FP_ZERO;
          rsp_tag_d    = tag_q;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          fpu_valid_d  = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) launch = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      pop         = 1'b1;
      op_d        = fpu_op_e'(q_op);
      din1_d      = q_a;
      din2_d      = q_b;
      tag_d       = q_tag;
      cnt_d       = '0;
      fpu_valid_d = 1'b1;
      state_d     = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fpu_valid_q  <= 1'b0;
      op_q         <= FPU_ADD;
      din1_q       <= '0;
      din2_q       <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpu_valid_q  <= fpu_valid_d;
      op_q         <= op_d;
      din1_q       <= din1_d;
      din2_q       <= din2_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign cmd_ready  = ~fifo_full;
  assign fpu_valid  = fpu_valid_q;
  assign fpu_op_sel = op_q;
  assign fpu_din1   = din1_q;
  assign fpu_din2   = din2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = ~fifo_empty || (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed bench for fpu_cmd_issuer with a behavioural FPU whose ready delay is adjustable.
module tb_fpu_cmd_issuer;
  import fpu_pkg::*;

  localparam int TAG_W = 4;
  localparam int W     = 32 + TAG_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0, cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [31:0]      cmd_a = '0, cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             fpu_valid;
  logic [1:0]       fpu_op_sel;
  logic [31:0]      fpu_din1, fpu_din2;
  logic [31:0]      fpu_result = '0;
  logic             fpu_ready = 1'b0;
  logic             rsp_valid, rsp_err, busy;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  issuer_state_e    state_dbg;

  fpu_cmd_issuer #(.CMD_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .fpu_valid  (fpu_valid),
    .fpu_op_sel (fpu_op_sel),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_result (fpu_result),
    .fpu_ready  (fpu_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- behavioural FPU ----------------
  logic ready_en = 1'b1;
  int   ready_delay = 3;
  int   mcnt = 0;

  function automatic logic [31:0] fp_model(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [65:0] k;
    k = {op, a, b};
    case (k)
      {2'b00, 32'h3F800000, 32'h40000000}: fp_model = 32'h40400000; // 1+2
      {2'b10, 32'h40400000, 32'h40000000}: fp_model = 32'h40C00000; // 3*2
      {2'b11, 32'h40C00000, 32'h40000000}: fp_model = 32'h40400000; // 6/2
      {2'b00, 32'h3F800000, 32'h3F800000}: fp_model = 32'h40000000; // 1+1
      {2'b01, 32'h40000000, 32'h3F800000}: fp_model = 32'h3F800000; // 2-1
      {2'b10, 32'h40000000, 32'h40000000}: fp_model = 32'h40800000; // 2*2
      {2'b11, 32'h40800000, 32'h40000000}: fp_model = 32'h40000000; // 4/2
      {2'b00, 32'h3F800000, 32'h00000000}: fp_model = 32'h3F800000; // 1+0
      default:                             fp_model = 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (fpu_valid !== 1'b1) begin
      mcnt      <= 0;
      fpu_ready <= 1'b0;
    end else begin
      mcnt       <= mcnt + 1;
      fpu_ready  <= ready_en && (mcnt + 1 >= ready_delay);
      fpu_result <= fp_model(fpu_op_sel, fpu_din1, fpu_din2);
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                          input logic exp_err);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_q.push_back({exp_res, tag, exp_err});
  endtask

  task automatic wait_rsp(input logic keep_ready);
    int n;
    logic [W-1:0] e;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_wait", rsp_valid, 1'b1);
    chk("exp_q_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_result", rsp_result, e[W-1:TAG_W+1]);
      chk("rsp_tag", rsp_tag, e[TAG_W:1]);
      chk("rsp_err", rsp_err, e[0]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = keep_ready;
  endtask

  task automatic count_issue(output int n);
    int w;
    w = 0;
    while (!fpu_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("fpu_valid_rise", fpu_valid, 1'b1);
    n = 0;
    while (fpu_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fpu_valid", fpu_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din1", fpu_din1, 32'h0);
    chk("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // 1: single add, inputs held while valid, then dropped
    ready_delay = 3;
    push_cmd(2'b00, FP_ONE, 32'h40000000, 4'd3, 32'h40400000, 1'b0);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_fpu_valid", fpu_valid, 1'b1);
    n = 0;
    while (fpu_valid && n < 100) begin
      chk("t1_op", fpu_op_sel, 2'b00);
      chk("t1_din1", fpu_din1, FP_ONE);
      chk("t1_din2", fpu_din2, 32'h40000000);
      @(negedge clk);
      n++;
    end
    chk("t1_issue_cycles", n, 4);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_din1_hold", fpu_din1, FP_ONE);
    wait_rsp(1'b0);
    chk("t1_idle_valid", fpu_valid, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_rsp", rsp_valid, 1'b0);

    // minimum latency: push at N -> fpu_valid at N+2 -> rsp_valid at N+4
    ready_delay = 1;
    push_cmd(2'b10, 32'h40400000, 32'h40000000, 4'd9, 32'h40C00000, 1'b0);
    chk("lat_n1_valid", fpu_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_valid", fpu_valid, 1'b1);
    @(negedge clk);
    chk("lat_n3_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk("lat_n4_rsp", rsp_valid, 1'b1);
    wait_rsp(1'b0);

    // 2: back-to-back commands, responses in order
    ready_delay = 2;
    rsp_ready = 1'b1;
    push_cmd(2'b10, 32'h40400000, 32'h40000000, 4'd1, 32'h40C00000, 1'b0);
    push_cmd(2'b11, 32'h40C00000, 32'h40000000, 4'd2, 32'h40400000, 1'b0);
    wait_rsp(1'b1);
    wait_rsp(1'b1);
    rsp_ready = 1'b0;
    chk("t2_idle_busy", busy, 1'b0);

    // 3: response backpressure holds outputs and blocks the next issue
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd5, 32'h40000000, 1'b0);
    push_cmd(2'b01, 32'h40000000, FP_ONE, 4'd6, FP_ONE, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_result", rsp_result, 32'h40000000);
      chk("t3_hold_tag", rsp_tag, 4'd5);
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_no_issue", fpu_valid, 1'b0);
      @(negedge clk);
    end
    wait_rsp(1'b0);
    chk("t3_next_issue", fpu_valid, 1'b1);
    chk("t3_next_op", fpu_op_sel, 2'b01);
    chk("t3_rsp_drop", rsp_valid, 1'b0);
    wait_rsp(1'b0);

    // 4: fill the FIFO behind a stalled operation
    ready_en = 1'b0;
    ready_delay = 1;
    push_cmd(2'b10, 32'h40400000, 32'h40000000, 4'd8, FP_ZERO, 1'b1);
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd9, 32'h40000000, 1'b0);
    push_cmd(2'b10, 32'h40000000, 32'h40000000, 4'd10, 32'h40800000, 1'b0);
    push_cmd(2'b01, 32'h40000000, FP_ONE, 4'd11, FP_ONE, 1'b0);
    push_cmd(2'b11, 32'h40800000, 32'h40000000, 4'd12, 32'h40000000, 1'b0);
    chk("t4_full", cmd_ready, 1'b0);
    chk("t4_state", state_dbg, ISSUE);
    wait_rsp(1'b0);
    chk("t4_one_slot", cmd_ready, 1'b1);
    push_cmd(2'b00, FP_ONE, FP_ZERO, 4'd13, FP_ONE, 1'b0);
    chk("t4_full_again", cmd_ready, 1'b0);
    ready_en = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_rsp(1'b1);
    rsp_ready = 1'b0;
    chk("t4_drained", busy, 1'b0);

    // 5: timeout abort after exactly 64 issue cycles, then normal operation
    ready_en = 1'b0;
    push_cmd(2'b00, FP_ONE, 32'h40000000, 4'd4, FP_ZERO, 1'b1);
    count_issue(n);
    chk("t5_issue_cycles", n, 64);
    wait_rsp(1'b0);
    ready_en = 1'b1;
    ready_delay = 2;
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd7, 32'h40000000, 1'b0);
    wait_rsp(1'b0);

    // ready arriving on the final timeout cycle completes without error
    ready_delay = 63;
    push_cmd(2'b00, FP_ONE, FP_ZERO, 4'd11, FP_ONE, 1'b0);
    count_issue(n);
    chk("t5b_issue_cycles", n, 64);
    wait_rsp(1'b0);

    // 6: reset in the middle of ISSUE with two commands queued
    ready_en = 1'b0;
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd1, 32'h40000000, 1'b0);
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd2, 32'h40000000, 1'b0);
    push_cmd(2'b00, FP_ONE, FP_ONE, 4'd3, 32'h40000000, 1'b0);
    chk("t6_pre_state", state_dbg, ISSUE);
    chk("t6_pre_valid", fpu_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_fpu_valid", fpu_valid, 1'b0);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    ready_en = 1'b1;
    ready_delay = 1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || fpu_valid) seen++;
    end
    chk("t6_no_stale", seen, 0);
    chk("t6_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
